// File: rtl/adc_burst_scheduler_pkg.sv
// Shared definitions for the ADC burst scheduler: FSM state encoding,
// default burst/address geometry and the width of the completed-burst counter.
package adc_burst_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int BURST_LEN_DEFAULT  = 8;
    localparam int ADDR_WIDTH_DEFAULT = 21;
    localparam int BURST_COUNT_WIDTH  = 16;

endpackage

// File: rtl/adc_burst_scheduler_burst_packer.sv
// Burst packer: collects BURST_LEN samples into one flat word, sample 0 in
// the LSBs. The word only changes while load is high.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load         write sample into the selected slot this cycle
//   slot         slot index, 0 .. BURST_LEN-1
//   sample       DATA_WIDTH sample from the FIFO
//   packed_word  DATA_WIDTH*BURST_LEN packed burst
module adc_burst_scheduler_burst_packer
    import adc_burst_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = BURST_LEN_DEFAULT,
    localparam int SLOT_W    = $clog2(BURST_LEN)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load,
    input  logic [SLOT_W-1:0]               slot,
    input  logic [DATA_WIDTH-1:0]           sample,
    output logic [DATA_WIDTH*BURST_LEN-1:0] packed_word
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            packed_word <= '0;
        end else if (load) begin
            packed_word[slot*DATA_WIDTH +: DATA_WIDTH] <= sample;
        end
    end

endmodule

// File: rtl/adc_burst_scheduler.sv
// ADC burst scheduler: drains fixed-length bursts from the sample FIFO,
// packs them into one wide word and issues PSRAM write commands at an
// auto-incrementing, wrapping word address.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            acquisition armed; a rising edge starts a new capture
//   fifo_level/full   FIFO occupancy (one-cycle lag) and full flag
//   fifo_data         FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en        FIFO read strobe
//   mem_cmd_valid/ready, mem_addr, mem_wdata   PSRAM write command
//   mem_done          one-cycle pulse when the PSRAM write completes
//   busy              FSM not in IDLE
//   overflow          sticky: FIFO full seen while enabled
//   wrapped           sticky: address wrapped since capture start
//   burst_count       completed bursts since capture start, saturating
module adc_burst_scheduler
    import adc_burst_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BURST_LEN   = BURST_LEN_DEFAULT,
    parameter int LEVEL_WIDTH = 7,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [LEVEL_WIDTH-1:0]          fifo_level,
    input  logic                            fifo_full,
    input  logic [DATA_WIDTH-1:0]           fifo_data,
    output logic                            fifo_rd_en,
    output logic                            mem_cmd_valid,
    input  logic                            mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH*BURST_LEN-1:0] mem_wdata,
    input  logic                            mem_done,
    output logic                            busy,
    output logic                            overflow,
    output logic                            wrapped,
    output logic [BURST_COUNT_WIDTH-1:0]    burst_count
);

    localparam int SLOT_W = $clog2(BURST_LEN);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_THRESH = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0]    ADDR_STEP    = (ADDR_WIDTH+1)'(BURST_LEN);
    localparam logic [SLOT_W-1:0]      LAST_SLOT    = SLOT_W'(BURST_LEN-1);

    state_t              state;
    logic [SLOT_W-1:0]   rd_idx;
    logic                vld_p1;      // fifo_data valid this cycle
    logic [SLOT_W-1:0]   slot_p1;     // packer slot for that sample
    logic                enable_d;
    logic                enable_rise;
    logic                start_pend;  // rise seen mid-burst, clear on return to IDLE
    logic [ADDR_WIDTH:0] addr_sum;    // MSB is the wrap carry

    assign enable_rise = enable & ~enable_d;
    assign addr_sum    = {1'b0, mem_addr} + ADDR_STEP;
    assign busy        = (state != IDLE);

    adc_burst_scheduler_burst_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_burst_packer (
        .clk         (clk),
        .reset       (reset),
        .load        (vld_p1),
        .slot        (slot_p1),
        .sample      (fifo_data),
        .packed_word (mem_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            fifo_rd_en    <= 1'b0;
            mem_cmd_valid <= 1'b0;
            mem_addr      <= '0;
            overflow      <= 1'b0;
            wrapped       <= 1'b0;
            burst_count   <= '0;
            rd_idx        <= '0;
            vld_p1        <= 1'b0;
            slot_p1       <= '0;
            enable_d      <= 1'b0;
            start_pend    <= 1'b0;
        end else begin
            enable_d <= enable;

            // Stage p0 -> p1: FIFO returns data one cycle after the strobe.
            vld_p1 <= fifo_rd_en;
            if (vld_p1) begin
                slot_p1 <= slot_p1 + SLOT_W'(1);
            end

            // Set has priority over the capture-start clear below.
            overflow <= overflow | (enable & fifo_full);

            if (enable_rise && state != IDLE) begin
                start_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable_rise || start_pend) begin
                        mem_addr    <= '0;
                        burst_count <= '0;
                        wrapped     <= 1'b0;
                        overflow    <= enable & fifo_full;
                        start_pend  <= 1'b0;
                    end
                    // Threshold is only evaluated here, so the lagging level
                    // can never trigger a read past the buffered samples.
                    if (enable && fifo_level >= LEVEL_THRESH) begin
                        state      <= FILL;
                        fifo_rd_en <= 1'b1;
                        rd_idx     <= '0;
                    end
                end
                FILL: begin
                    if (fifo_rd_en) begin
                        rd_idx <= rd_idx + SLOT_W'(1);
                        if (rd_idx == LAST_SLOT) begin
                            fifo_rd_en <= 1'b0;
                        end
                    end
                    if (vld_p1 && slot_p1 == LAST_SLOT) begin
                        state         <= ISSUE;
                        mem_cmd_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        state         <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (mem_done) begin
                        mem_addr <= addr_sum[ADDR_WIDTH-1:0];
                        if (addr_sum[ADDR_WIDTH]) begin
                            wrapped <= 1'b1;
                        end
                        if (burst_count != '1) begin
                            burst_count <= burst_count + BURST_COUNT_WIDTH'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_burst_scheduler.sv
// Testbench for adc_burst_scheduler. A queue-based FIFO emulation feeds the
// design; expected bursts are consecutive groups of BURST_LEN pushed samples,
// and the address/count/flag expectations follow from counting completed
// bursts. A small address width makes wrap-around reachable.
module tb_adc_burst_scheduler;

    localparam int DW  = 16;
    localparam int BL  = 8;
    localparam int LW  = 7;
    localparam int AW  = 7;
    localparam int CAP = 40;
    localparam int MW  = DW * BL;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wdata;
    logic          mem_done;
    logic          busy;
    logic          overflow;
    logic          wrapped;
    logic [15:0]   burst_count;

    always #5 clk = ~clk;

    adc_burst_scheduler #(
        .DATA_WIDTH  (DW),
        .BURST_LEN   (BL),
        .LEVEL_WIDTH (LW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_level    (fifo_level),
        .fifo_full     (fifo_full),
        .fifo_data     (fifo_data),
        .fifo_rd_en    (fifo_rd_en),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_done      (mem_done),
        .busy          (busy),
        .overflow      (overflow),
        .wrapped       (wrapped),
        .burst_count   (burst_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // FIFO emulation and reference model state
    int            q[$];
    int            hist[$];
    int            bursts_taken;
    int            exp_addr;
    int            exp_cnt;
    bit            exp_wrap;
    bit            exp_ovf;
    bit            outstanding;
    int            done_timer;
    bit            done_chk;
    bit            prev_rd;
    int            rd_count_cur;
    bit            hold_valid;
    logic [AW-1:0] hold_addr;
    logic [MW-1:0] hold_wdata;
    int            lvl_prev;
    bit            en_prev;
    int            cyc;
    int            accept_count;
    bit            accepted_now;
    int            rise_cyc;
    int            first_rd_cyc;
    int            first_valid_cyc;
    logic [AW-1:0] first_valid_addr;
    logic [MW-1:0] first_valid_wdata;

    // stimulus controls
    int produce_pct;
    int ready_pct;
    int done_max;
    bit spurious_en;
    bit force_full;
    bit en_req;

    function automatic logic [MW-1:0] expected_word(input int b);
        logic [MW-1:0] w;
        w = '0;
        for (int i = 0; i < BL; i++) begin
            if (b * BL + i < hist.size()) w[i*DW +: DW] = DW'(hist[b*BL+i]);
        end
        return w;
    endfunction

    task automatic push_sample(input int v);
        q.push_back(v);
        hist.push_back(v);
    endtask

    // One clock cycle: observe outputs just after the edge, update the model,
    // then drive inputs for the cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        accepted_now = 0;

        chk("overflow", overflow, exp_ovf);
        if (done_chk) begin
            chk("burst_count", burst_count, exp_cnt);
            chk("addr_after_done", mem_addr, exp_addr);
            chk("wrapped", wrapped, exp_wrap);
            done_chk = 0;
        end
        if (hold_valid) begin
            chk("valid_held", mem_cmd_valid, 1);
            chk("addr_stable", mem_addr, hold_addr);
            chk("wdata_stable", mem_wdata, hold_wdata);
        end else if (mem_cmd_valid) begin
            first_valid_cyc   = cyc;
            first_valid_addr  = mem_addr;
            first_valid_wdata = mem_wdata;
            chk("rd_en_cycles", rd_count_cur, BL);
            rd_count_cur = 0;
            chk("cmd_addr", mem_addr, exp_addr);
            chk("cmd_wdata", mem_wdata, expected_word(bursts_taken));
        end
        if (fifo_rd_en && rd_count_cur == 0) first_rd_cyc = cyc;
        if (fifo_rd_en) rd_count_cur++;

        if (prev_rd) begin
            chk("no_underread", q.size() > 0, 1);
            if (q.size() > 0) fifo_data = DW'(q.pop_front());
        end
        prev_rd = fifo_rd_en;

        if (produce_pct > 0 && $urandom_range(99) < produce_pct && q.size() < CAP)
            push_sample(int'($urandom_range(16'hFFFF)));
        fifo_level = LW'(lvl_prev);
        lvl_prev   = q.size();
        fifo_full  = (q.size() >= CAP) || force_full;

        mem_cmd_ready = ($urandom_range(99) < ready_pct);
        mem_done = 0;
        if (outstanding) begin
            done_timer--;
            if (done_timer == 0) begin
                mem_done    = 1;
                outstanding = 0;
                done_chk    = 1;
                exp_addr    = exp_addr + BL;
                if (exp_addr >= (1 << AW)) begin
                    exp_addr = exp_addr - (1 << AW);
                    exp_wrap = 1;
                end
                if (exp_cnt < 65535) exp_cnt++;
            end
        end else if (spurious_en && $urandom_range(9) == 0) begin
            mem_done = 1;
        end

        if (mem_cmd_valid && mem_cmd_ready) begin
            accepted_now = 1;
            accept_count++;
            bursts_taken++;
            outstanding = 1;
            done_timer  = $urandom_range(done_max, 1);
            hold_valid  = 0;
        end else begin
            hold_valid = mem_cmd_valid;
            hold_addr  = mem_addr;
            hold_wdata = mem_wdata;
        end

        enable = en_req;
        if (en_req && !en_prev) begin
            rise_cyc = cyc;
            exp_addr = 0;
            exp_cnt  = 0;
            exp_wrap = 0;
            exp_ovf  = 0;
        end
        en_prev = en_req;
        if (enable && fifo_full) exp_ovf = 1;
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_cmd_valid", mem_cmd_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_count", burst_count, 0);
        q.delete();
        hist.delete();
        bursts_taken = 0;
        exp_addr = 0; exp_cnt = 0; exp_wrap = 0; exp_ovf = 0;
        outstanding = 0; done_chk = 0; prev_rd = 0; rd_count_cur = 0;
        hold_valid = 0; lvl_prev = 0; force_full = 0;
        fifo_level = '0; fifo_full = 0; fifo_data = '0;
        mem_done = 0; mem_cmd_ready = 0;
        enable = en_req;
        en_prev = en_req;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int t0;
        bit hit;
        reset = 1; enable = 0; fifo_full = 0; fifo_level = '0; fifo_data = '0;
        mem_cmd_ready = 0; mem_done = 0;
        produce_pct = 0; ready_pct = 100; done_max = 1; spurious_en = 0;
        force_full = 0; en_req = 0; cyc = 0; accept_count = 0;
        first_rd_cyc = 0; first_valid_cyc = 0; rise_cyc = 0;
        do_reset();

        // Basic burst: samples 1..8
        for (int i = 1; i <= BL; i++) push_sample(i);
        step();
        en_req = 1;
        step();
        t0 = rise_cyc;
        for (int i = 0; i < 40 && accept_count == 0; i++) step();
        chk("t1_accepted", accept_count, 1);
        chk("t1_rd_start", first_rd_cyc - t0, 1);
        chk("t1_valid_latency", first_valid_cyc - t0, BL + 2);
        chk("t1_addr", first_valid_addr, 0);
        chk("t1_wdata", first_valid_wdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        repeat (3) step();
        chk("t1_addr_next", mem_addr, 8);
        chk("t1_count", burst_count, 1);

        // Backpressure: ready low for 20 cycles
        ready_pct = 0;
        for (int i = 0; i < BL; i++) push_sample(16'h0100 + i);
        for (int i = 0; i < 40 && !mem_cmd_valid; i++) step();
        chk("t2_valid_up", mem_cmd_valid, 1);
        a0 = accept_count;
        repeat (20) step();
        chk("t2_still_valid", mem_cmd_valid, 1);
        chk("t2_no_accept", accept_count, a0);
        ready_pct = 100;
        repeat (6) step();
        chk("t2_one_accept", accept_count, a0 + 1);
        chk("t2_count", burst_count, 2);
        chk("t2_addr", mem_addr, 16);

        // Randomized traffic
        produce_pct = 60; ready_pct = 50; done_max = 4; spurious_en = 1;
        repeat (2500) step();

        // Stop, then restart capture after the address has wrapped
        produce_pct = 0; spurious_en = 0; ready_pct = 100; done_max = 1;
        en_req = 0;
        repeat (60) step();
        chk("quiet_busy", busy, 0);
        chk("pre_restart_wrapped", wrapped, 1);
        en_req = 1;
        step();
        step();
        chk("restart_addr", mem_addr, 0);
        chk("restart_count", burst_count, 0);
        chk("restart_wrapped", wrapped, 0);

        // Drain residue and start a clean capture
        repeat (120) step();
        en_req = 0;
        step();
        en_req = 1;
        step();
        step();
        chk("ovf_pre", overflow, 0);

        // fifo_full pulse during WAIT_DONE
        done_max = 6;
        for (int i = 0; i < BL; i++) push_sample(16'h0A00 + i);
        for (int i = 0; i < 40 && !accepted_now; i++) step();
        chk("ovf_accepted", accepted_now, 1);
        force_full = 1;
        step();
        force_full = 0;
        repeat (10) step();
        chk("ovf_sticky", overflow, 1);
        en_req = 0;
        step();
        en_req = 1;
        step();
        step();
        chk("ovf_cleared", overflow, 0);

        // Level one short of the threshold
        done_max = 1;
        en_req = 0;
        do_reset();
        for (int i = 0; i < BL - 1; i++) push_sample(16'h0200 + i);
        step();
        en_req = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("l7_no_rd", fifo_rd_en, 0);
            chk("l7_idle", busy, 0);
        end
        push_sample(16'h0207);
        for (int i = 0; i < 10 && !fifo_rd_en; i++) step();
        chk("l7_started", fifo_rd_en, 1);
        a0 = accept_count;
        for (int i = 0; i < 40 && accept_count == a0; i++) step();
        repeat (3) step();
        chk("l7_count", burst_count, 1);

        // Reset on the third FILL cycle
        for (int i = 0; i < BL; i++) push_sample(16'h0300 + i);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = (rd_count_cur == 3);
        end
        chk("mid_fill_reached", hit, 1);
        do_reset();
        for (int i = 0; i < BL; i++) push_sample(16'h0400 + i);
        a0 = accept_count;
        for (int i = 0; i < 40 && accept_count == a0; i++) step();
        chk("post_rst_accept", accept_count, a0 + 1);
        chk("post_rst_addr", first_valid_addr, 0);
        chk("post_rst_count0", burst_count, 0);
        repeat (3) step();
        chk("post_rst_addr_next", mem_addr, 8);
        chk("post_rst_count1", burst_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
